// File: rtl/req_unpacker.sv
// Width converter: repacks IW-bit input words into an LSB-first stream of OW-bit output words.
// Uses a 2*IW-bit shift buffer and a single registered output slot with valid/ready handshaking.
module req_unpacker #(
    parameter int IW = 64,
    parameter int OW = 56
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [IW-1:0] in,
    input  logic          ivalid,
    output logic          iready,
    output logic [OW-1:0] out,
    output logic          ovalid,
    input  logic          oready,
    output logic [7:0]    level
);

    localparam int BW = 2 * IW;
    localparam logic [7:0] OW_C = 8'(OW);
    localparam logic [7:0] IW_C = 8'(IW);

    logic [BW-1:0] data_q, data_d, shifted;
    logic [7:0]    count_q, count_d, cap;
    logic          free, pop, push;

    // Pop happens before push, so the new word is written at the post-shift fill level.
    always_comb begin
        free    = !ovalid || oready;
        pop     = free && (count_q >= OW_C);
        cap     = pop ? (count_q - OW_C) : count_q;
        iready  = (cap <= IW_C);
        push    = ivalid && iready;
        shifted = pop ? (data_q >> OW) : data_q;
        data_d  = shifted;
        count_d = cap;
        if (push) begin
            data_d  = shifted | (BW'(in) << cap);
            count_d = cap + IW_C;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            count_q <= '0;
            out     <= '0;
            ovalid  <= 1'b0;
        end else begin
            data_q  <= data_d;
            count_q <= count_d;
            if (pop) begin
                out    <= data_q[OW-1:0];
                ovalid <= 1'b1;
            end else if (free) begin
                ovalid <= 1'b0;
            end
        end
    end

    assign level = count_q;

endmodule

// File: tb/tb_req_unpacker.sv
// Bench for req_unpacker: directed scenarios plus random traffic, compared against a
// bit-queue reference model of the output stream.
module tb_req_unpacker;

    localparam int IW = 64;
    localparam int OW = 56;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [IW-1:0] in_w = '0;
    logic          ivalid = 1'b0;
    logic          iready;
    logic [OW-1:0] out;
    logic          ovalid;
    logic          oready = 1'b0;
    logic [7:0]    level;

    always #5 clk = ~clk;

    req_unpacker #(.IW(IW), .OW(OW)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .in     (in_w),
        .ivalid (ivalid),
        .iready (iready),
        .out    (out),
        .ovalid (ovalid),
        .oready (oready),
        .level  (level)
    );

    int tests = 0;
    int fails = 0;

    // Reference: queue of pending stream bits, oldest first, plus the output slot.
    bit            mq[$];
    logic [OW-1:0] m_out = '0;
    logic          m_ovalid = 1'b0;
    logic          obs_ready;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        mq.delete();
        m_out    = '0;
        m_ovalid = 1'b0;
    endtask

    // Entered at posedge+1; leaves at the next posedge+1.
    task automatic cycle(input logic iv, input logic [IW-1:0] d, input logic ordy);
        int   cnt;
        logic mfree, mpop, mready;
        ivalid = iv;
        in_w   = d;
        oready = ordy;
        #1;
        cnt    = mq.size();
        mfree  = !m_ovalid || ordy;
        mpop   = mfree && (cnt >= OW);
        mready = ((cnt - (mpop ? OW : 0)) <= IW);
        obs_ready = iready;
        check("iready", 128'(iready), 128'(mready));
        @(posedge clk);
        if (mpop) begin
            for (int i = 0; i < OW; i++) m_out[i] = mq.pop_front();
            m_ovalid = 1'b1;
        end else if (mfree) begin
            m_ovalid = 1'b0;
        end
        if (iv && mready)
            for (int i = 0; i < IW; i++) mq.push_back(d[i]);
        #1;
        check("out", 128'(out), 128'(m_out));
        check("ovalid", 128'(ovalid), 128'(m_ovalid));
        check("level", 128'(level), 128'(mq.size()));
    endtask

    // Asserts reset dly after posedge+1, checks the immediate effect, releases at posedge+1.
    task automatic do_reset(input int dly);
        ivalid = 1'b0;
        #(dly);
        rst_n = 1'b0;
        #1;
        check("rst_ovalid", 128'(ovalid), 128'(0));
        check("rst_level", 128'(level), 128'(0));
        check("rst_out", 128'(out), 128'(0));
        check("rst_iready", 128'(iready), 128'(1));
        model_clear();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    logic [IW-1:0] d;
    logic [IW-1:0] w;
    logic [OW-1:0] held;
    int            lows, first_low, last_low, gaps, seen, nvalid;

    initial begin
        // Power-on reset state
        #1;
        check("por_ovalid", 128'(ovalid), 128'(0));
        check("por_level", 128'(level), 128'(0));
        check("por_out", 128'(out), 128'(0));
        check("por_iready", 128'(iready), 128'(1));
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Basic split
        cycle(1'b1, 64'h0706050403020100, 1'b1);
        check("split_lvl0", 128'(level), 128'(64));
        cycle(1'b1, 64'h0F0E0D0C0B0A0908, 1'b1);
        check("split_out0", 128'(out), 128'(56'h06050403020100));
        cycle(1'b0, '0, 1'b1);
        check("split_out1", 128'(out), 128'(56'h0D0C0B0A090807));
        check("split_lvl1", 128'(level), 128'(16));
        cycle(1'b0, '0, 1'b1);
        check("split_idle_ov", 128'(ovalid), 128'(0));
        check("split_idle_lvl", 128'(level), 128'(16));

        // Streaming with an incrementing byte pattern
        do_reset(0);
        lows = 0; first_low = -1; last_low = -1; gaps = 0; seen = 0;
        for (int k = 0; k < 64; k++) begin
            for (int b = 0; b < 8; b++) d[8*b +: 8] = 8'(8 * k + b);
            cycle(1'b1, d, 1'b1);
            if (!obs_ready) begin
                if (first_low < 0) first_low = k;
                else check("stream_spacing", 128'(k - last_low), 128'(8));
                last_low = k;
                lows++;
            end
            if (seen != 0 && !ovalid) gaps++;
            if (ovalid) seen = 1;
        end
        check("stream_lows", 128'(lows), 128'(7));
        check("stream_first_low", 128'(first_low), 128'(9));
        check("stream_gaps", 128'(gaps), 128'(0));

        // Backpressure up to a full buffer, then drain
        do_reset(0);
        for (int k = 0; k < 8; k++) cycle(1'b1, {$urandom, $urandom}, 1'b1);
        cycle(1'b0, '0, 1'b1);
        check("bp_lvl64", 128'(level), 128'(64));
        held = out;
        for (int k = 0; k < 4; k++) begin
            cycle(1'b1, {$urandom, $urandom}, 1'b0);
            check("bp_hold", 128'(out), 128'(held));
            check("bp_lvl128", 128'(level), 128'(128));
        end
        check("bp_full_ready", 128'(obs_ready), 128'(0));
        for (int k = 0; k < 4; k++) cycle(1'b0, '0, 1'b1);
        check("bp_drained", 128'(level), 128'(16));

        // Underflow: one word yields exactly one output
        do_reset(0);
        cycle(1'b1, {$urandom, $urandom}, 1'b1);
        nvalid = 0;
        for (int k = 0; k < 5; k++) begin
            cycle(1'b0, '0, 1'b1);
            if (ovalid) nvalid++;
        end
        check("uf_count", 128'(nvalid), 128'(1));
        check("uf_level", 128'(level), 128'(8));
        check("uf_ovalid", 128'(ovalid), 128'(0));

        // Asynchronous reset between edges in mid-stream
        for (int k = 0; k < 5; k++) cycle(1'b1, {$urandom, $urandom}, 1'b1);
        do_reset(2);
        w = {$urandom, $urandom};
        cycle(1'b1, w, 1'b1);
        cycle(1'b0, '0, 1'b1);
        check("rst_push_out", 128'(out), 128'(w[OW-1:0]));
        check("rst_push_ov", 128'(ovalid), 128'(1));

        // Random traffic
        do_reset(0);
        for (int k = 0; k < 400; k++)
            cycle(($urandom_range(0, 3) != 0), {$urandom, $urandom}, ($urandom_range(0, 3) != 0));
        for (int k = 0; k < 6; k++) cycle(1'b0, '0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
